i2s_serializer: RTL
===================

# i2s_serializer

Parallel-to-I2S transmitter for the codec DAC path, paired with the ADC-side I2S deserializer.
- Accepts one stereo sample at a time (24-bit left, 24-bit right) through a valid/ready handshake into a one-frame holding buffer.
- Shifts the sample out MSB-first on `o_codec_dac_data`, aligned to the codec-mastered bit clock and LR clock.
- Sits between the audio processing pipeline and the codec pins, all in the `i_clock` domain.

## Interface
Parameters:
- `DATA_WIDTH`, 24, bits per channel slot; a `bit_counter` of 5 bits covers it.

Ports:
- `i_clock` in 1: system clock, at least 8x the codec bit clock. One clock only.
- `i_reset` in 1: synchronous reset, active-high.
- `i_codec_bit_clock` in 1: codec BCLK, asynchronous to `i_clock`.
- `i_codec_lr_clock` in 1: codec LRCLK, asynchronous. Low = left slot, high = right slot.
- `o_codec_dac_data` out 1: serial DAC data, registered.
- `i_data_left` in DATA_WIDTH: left sample, two's complement.
- `i_data_right` in DATA_WIDTH: right sample, two's complement.
- `i_data_valid` in 1: sample pair valid.
- `o_data_ready` out 1: holding buffer empty; a transfer occurs when valid & ready.
- `o_underflow` out 1: one-cycle pulse when a frame starts with the holding buffer empty.

## Operation
Synchronizer and edge detect:
- BCLK and LRCLK each pass through a 2-FF synchronizer plus a delay flop.
- Rising/falling pulses are registered, one `i_clock` wide.

Holding buffer:
- `hold_left`, `hold_right`, `hold_full`.
- `o_data_ready = !hold_full && !i_reset`.
- On accept: capture both channels and set `hold_full`.
- The buffer is loaded only when `hold_full` is 0, so a pending sample is never overwritten.

Frame load (on every LR falling pulse, in any state):
- If `hold_full`: copy `hold_left`/`hold_right` into `shift_left`/`shift_right` and clear `hold_full`.
- Otherwise: load zeros into both and pulse `o_underflow`.
- An accept in the same cycle as a frame load fills the holding buffer. It is not used for the current frame.

FSM states:
- IDLE: output 0. Go to LEFT_WAIT on LR falling.
- LEFT_WAIT: wait for the first BCLK rising pulse (the I2S one-bit delay slot), then go to LEFT_SHIFT.
- LEFT_SHIFT: on each BCLK falling pulse:
  - `o_codec_dac_data <= shift_left[MSB]`
  - shift left by 1
  - `bit_counter++`
  - When `bit_counter` reaches DATA_WIDTH, clear it and go to WAIT_LR_RISE.
- WAIT_LR_RISE: drive 0. Go to RIGHT_WAIT on LR rising.
- RIGHT_WAIT / RIGHT_SHIFT: same as the left pair, using `shift_right`. After DATA_WIDTH bits, go to WAIT_LR_FALL.
- WAIT_LR_FALL: drive 0. On LR falling, do the frame load and go to LEFT_WAIT.

Boundary conditions:
- Short slot: an LR edge arriving in any SHIFT or WAIT state aborts the slot.
  - Clear `bit_counter` and drive 0.
  - LR falling: jump to LEFT_WAIT with a frame load.
  - LR rising: jump to RIGHT_WAIT.
- Long slot: bits after the DATA_WIDTH-th are driven 0 until the next LR edge.
- Reset mid-operation, on the next `i_clock` edge:
  - FSM goes to IDLE.
  - Holding buffer is discarded (`hold_full` = 0).
  - Shift registers and `bit_counter` are cleared.
  - Output resynchronizes at the next LR falling edge; no partial frame is resumed.

## Timing
Reset values:
- `o_codec_dac_data` = 0
- `o_underflow` = 0
- `o_data_ready` = 0 while `i_reset` is high, 1 on the first cycle after release
- FSM = IDLE, all registers 0

Latencies:
- Pin BCLK falling to `o_codec_dac_data` change: 4 `i_clock` cycles (2 sync, 1 edge register, 1 output register). This is constant, so bits are stable for the codec's BCLK rising sample given `i_clock` ≥ 8x BCLK.
- Accept to `o_data_ready` low: next cycle.
- `o_data_ready` high again: the cycle after the frame load that consumes the buffer.
- Sample accepted before an LR falling pulse: left MSB appears on the BCLK falling edge that follows the first post-LR BCLK rising edge.
- Throughput: one sample pair per LR period.

## Test plan
- **Basic frame:** reset, then accept L=24'hA5F00F, R=24'h123456; drive 64 BCLK/frame → the serial stream sampled on BCLK rising (bits 2..25 of each slot) equals A5F00F then 123456; `o_underflow` stays 0; the next frame is zeros with one `o_underflow` pulse.
- **Backpressure:** hold `i_data_valid` high with 3 distinct pairs → `o_data_ready` drops after the first accept; the pairs are transmitted in order, one per frame, none lost or duplicated.
- **Extremes:** L=24'h800000, R=24'h7FFFFF → exact bit patterns on the wire; the remaining 7 bits of each 32-bit slot are 0.
- **Short slot:** 16 BCLK per slot → only the 15 MSBs of each channel are emitted; FSM resyncs each frame; no hang.
- **Reset mid-left-slot:** after 10 bits, reset → output 0 next cycle, `o_data_ready` = 1 after release; newly accepted data is emitted starting at the next LR falling edge.
- **Loopback:** connect to the I2S deserializer with a shared BCLK/LRCLK model → its left/right outputs equal the transmitted pairs over 100 random samples.

Source files
------------

// File: rtl/i2s_serializer.sv
// rtl/i2s_serializer.sv - stereo parallel-to-I2S transmitter with one-frame holding buffer
`timescale 1ns/1ps
module i2s_serializer #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_codec_bit_clock,
    input  logic                  i_codec_lr_clock,
    output logic                  o_codec_dac_data,
    input  logic [DATA_WIDTH-1:0] i_data_left,
    input  logic [DATA_WIDTH-1:0] i_data_right,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_underflow
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEFT_WAIT,
        S_LEFT_SHIFT,
        S_WAIT_LR_RISE,
        S_RIGHT_WAIT,
        S_RIGHT_SHIFT,
        S_WAIT_LR_FALL
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_bclk_sync;
    logic [1:0]            r_lr_sync;
    logic                  r_bclk_dly;
    logic                  r_lr_dly;
    logic                  r_bclk_rise;
    logic                  r_bclk_fall;
    logic                  r_lr_rise;
    logic                  r_lr_fall;
    logic [DATA_WIDTH-1:0] r_hold_left;
    logic [DATA_WIDTH-1:0] r_hold_right;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_shift_left;
    logic [DATA_WIDTH-1:0] r_shift_right;
    logic [CW-1:0]         r_bit_count;
    logic                  r_dac_data;
    logic                  r_underflow;
    logic                  w_accept;
    logic                  w_lr_edge;
    logic                  w_last_bit;
    logic                  w_shift_left_en;
    logic                  w_shift_right_en;
    logic                  w_count_clr;
    logic                  w_dac_next;

    assign o_data_ready     = ~r_hold_full & ~i_reset;
    assign o_codec_dac_data = r_dac_data;
    assign o_underflow      = r_underflow;
    assign w_accept         = i_data_valid & o_data_ready;
    assign w_lr_edge        = r_lr_rise | r_lr_fall;
    assign w_last_bit       = (r_bit_count == CW'(DATA_WIDTH - 1));

    // Fixed sync + edge-register depth keeps BCLK-fall to data-change latency constant.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_bclk_dly  <= 1'b0;
            r_lr_dly    <= 1'b0;
            r_bclk_rise <= 1'b0;
            r_bclk_fall <= 1'b0;
            r_lr_rise   <= 1'b0;
            r_lr_fall   <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], i_codec_bit_clock};
            r_lr_sync   <= {r_lr_sync[0], i_codec_lr_clock};
            r_bclk_dly  <= r_bclk_sync[1];
            r_lr_dly    <= r_lr_sync[1];
            r_bclk_rise <= r_bclk_sync[1] & ~r_bclk_dly;
            r_bclk_fall <= ~r_bclk_sync[1] & r_bclk_dly;
            r_lr_rise   <= r_lr_sync[1] & ~r_lr_dly;
            r_lr_fall   <= ~r_lr_sync[1] & r_lr_dly;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_lr_fall) begin
            w_state_next = S_LEFT_WAIT;
        end else if (r_lr_rise && (r_state != S_IDLE)) begin
            w_state_next = S_RIGHT_WAIT;
        end else begin
            case (r_state)
                S_LEFT_WAIT:   if (r_bclk_rise) w_state_next = S_LEFT_SHIFT;
                S_LEFT_SHIFT:  if (r_bclk_fall && w_last_bit) w_state_next = S_WAIT_LR_RISE;
                S_RIGHT_WAIT:  if (r_bclk_rise) w_state_next = S_RIGHT_SHIFT;
                S_RIGHT_SHIFT: if (r_bclk_fall && w_last_bit) w_state_next = S_WAIT_LR_FALL;
                default: ;
            endcase
        end
    end

    // Any LR edge aborts the current slot; otherwise data only moves on BCLK falling.
    always_comb begin
        w_shift_left_en  = 1'b0;
        w_shift_right_en = 1'b0;
        w_count_clr      = 1'b0;
        w_dac_next       = r_dac_data;
        if (w_lr_edge) begin
            w_count_clr = 1'b1;
            w_dac_next  = 1'b0;
        end else if (r_state == S_IDLE) begin
            w_dac_next = 1'b0;
        end else if (r_bclk_fall) begin
            case (r_state)
                S_LEFT_SHIFT: begin
                    w_shift_left_en = 1'b1;
                    w_dac_next      = r_shift_left[DATA_WIDTH-1];
                end
                S_RIGHT_SHIFT: begin
                    w_shift_right_en = 1'b1;
                    w_dac_next       = r_shift_right[DATA_WIDTH-1];
                end
                default: w_dac_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hold_left   <= '0;
            r_hold_right  <= '0;
            r_hold_full   <= 1'b0;
            r_shift_left  <= '0;
            r_shift_right <= '0;
            r_bit_count   <= '0;
            r_dac_data    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_underflow <= r_lr_fall & ~r_hold_full;
            r_dac_data  <= w_dac_next;
            if (w_accept) begin
                r_hold_left  <= i_data_left;
                r_hold_right <= i_data_right;
                r_hold_full  <= 1'b1;
            end else if (r_lr_fall) begin
                r_hold_full <= 1'b0;
            end
            if (r_lr_fall) begin
                r_shift_left  <= r_hold_full ? r_hold_left : '0;
                r_shift_right <= r_hold_full ? r_hold_right : '0;
            end else begin
                if (w_shift_left_en) begin
                    r_shift_left <= {r_shift_left[DATA_WIDTH-2:0], 1'b0};
                end
                if (w_shift_right_en) begin
                    r_shift_right <= {r_shift_right[DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (w_count_clr) begin
                r_bit_count <= '0;
            end else if (w_shift_left_en | w_shift_right_en) begin
                r_bit_count <= w_last_bit ? '0 : r_bit_count + CW'(1);
            end
        end
    end
endmodule
